imem_bridge: RTL
================

// Module: imem_bridge
// PURPOSE
//  Instruction-side bus bridge sitting directly upstream of the fetch stage.
//  - Accepts fetch word requests over req/gnt/addr and returns rdata/rvalid/err in request order.
//  - Converts them to a valid/ready read-address channel and a read-data channel toward instruction memory.
//  - Bounds outstanding reads, raises local access faults for out-of-range addresses, and discards responses on flush.
// PARAMETERS
//  NUM_REQS   2             max outstanding fetch requests (>=1); also the order-FIFO depth
//  ADDR_BASE  32'h0000_0000 lowest legal instruction address (inclusive)
//  ADDR_LIMIT 32'h0000_FFFF highest legal instruction address (inclusive)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  instr_req_i    in   1   fetch requests a word
//  instr_addr_i   in   32  request address; bits [1:0] are ignored (word access)
//  instr_gnt_o    out  1   request accepted this cycle (combinational)
//  instr_rvalid_o out  1   response valid (registered)
//  instr_rdata_o  out  32  response word
//  instr_err_o    out  1   response is a fault
//  flush_i        in   1   drop responses of all requests granted before this cycle
//  mem_arvalid_o  out  1   read-address valid
//  mem_araddr_o   out  32  read address, word aligned ([1:0]=0)
//  mem_arready_i  in   1   memory accepts address
//  mem_rvalid_i   in   1   memory read data valid
//  mem_rdata_i    in   32  memory read data
//  mem_rerr_i     in   1   memory read error
//  mem_rready_o   out  1   bridge accepts read data
// BEHAVIOUR
//  Reset values: gnt=0, rvalid=0, rdata=0, err=0, arvalid=0, araddr=0, rready=0.
//  Reset clears the counter, the order FIFO and the AR register; in-flight memory transactions are
//  assumed reset by the same rst.
//  State:
//  - outstanding counter cnt, width $clog2(NUM_REQS+1).
//  - order FIFO of NUM_REQS entries {local_err, discard}.
//  - AR holding register {arvalid, araddr}.
//  Range check: in_range = (addr >= ADDR_BASE) && (addr <= ADDR_LIMIT), unsigned compare on the full 32 bits.
//  Grant rule: gnt = instr_req_i && (cnt < NUM_REQS) && (!arvalid_q || mem_arready_i).
//  On gnt:
//  - push {!in_range, 0} to the FIFO.
//  - If in_range: load arvalid=1 and araddr={addr[31:2],2'b00}.
//  - Else: no memory access.
//  AR channel: arvalid holds with a stable address until mem_arready_i.
//  - An AR handshake and a new gnt in the same cycle reload the register with no bubble.
//  - arvalid clears when the handshake completes and there is no new load.
//  Completion: the head of the FIFO completes in one of two ways.
//  - Head local_err=1: completes unconditionally. Next cycle: rvalid=!discard, err=1, rdata=0.
//  - Head local_err=0: completes on mem_rvalid_i && mem_rready_o. Next cycle: rvalid=!discard,
//    rdata=mem_rdata_i, err=mem_rerr_i.
//  Memory-data acceptance: mem_rready_o = FIFO non-empty && !head.local_err.
//  - Memory data therefore waits behind older local faults, so order is preserved.
//  Completion pops the FIFO. cnt += gnt - pop; simultaneous gnt and pop leave cnt unchanged.
//  Latency: a response appears one cycle after mem_rvalid handshake; a local fault appears at least
//  one cycle after grant. Max one response per cycle.
//  rvalid is a one-cycle pulse per delivered response; rdata/err hold their last value otherwise.
//  Flush:
//  - flush_i sets discard on every FIFO entry present at the start of the cycle.
//  - A request granted in the same cycle as flush is NOT discarded.
//  - Discarded memory reads are still accepted (rready unchanged) and AR still completes.
//  - A response being registered in the flush cycle is suppressed.
//  Full: cnt==NUM_REQS forces gnt=0 until a pop. A pop and a new grant may occur in the same cycle.
//  Empty: rready=0 and any mem_rvalid_i is a protocol error (assertion); response outputs are idle.
// TESTING
//  1. Single fetch addr 0x100, arready=1, rvalid 2 cycles later with 0x00000013
//     -> gnt same cycle, araddr=0x100, rvalid=1 rdata=0x13 err=0 one cycle after data.
//  2. NUM_REQS=2, three back-to-back reqs (0x0, 0x4, 0x8), memory silent
//     -> gnt on the first two only, cnt=2; first data beat re-enables gnt for 0x8.
//  3. Req 0x20000 (out of range) then 0x10
//     -> no AR for 0x20000; err=1 rdata=0 delivered first, then the 0x10 data; rready=0 while the fault is at head.
//  4. Two reads outstanding, flush_i pulsed, new req 0x40 granted in the flush cycle
//     -> both old data beats accepted with rvalid=0; 0x40 response delivered with rvalid=1.
//  5. arready held 0 for 3 cycles with a pending address
//     -> araddr stable, gnt=0 for the next req until arready=1, then same-cycle reload.
//  6. rst asserted with 2 outstanding -> all outputs 0 asynchronously, cnt=0, next req granted immediately after release.

Source files
------------

// File: rtl/imem_bridge.sv
// imem_bridge: fetch req/gnt to valid/ready AR/R bridge with range faults, ordering and flush
module imem_bridge #(
  parameter int          NUM_REQS   = 2,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        flush_i,
  output logic        mem_arvalid_o,
  output logic [31:0] mem_araddr_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rerr_i,
  output logic        mem_rready_o
);
  localparam int CW = $clog2(NUM_REQS + 1);
  localparam int PW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_REQS);
  logic [CW-1:0]       cnt_q;
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [NUM_REQS-1:0] ferr_q, fdisc_q;
  logic                arvalid_q, rvalid_q, err_q;
  logic [31:0]         araddr_q, rdata_q;
  logic                in_range, empty, head_err, head_disc, pop, deliver;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(NUM_REQS - 1) ? '0 : p + 1'b1;
  endfunction
  // offset compare stays correct when ADDR_BASE is zero without a constant-true term
  always_comb begin
    in_range     = (instr_addr_i - ADDR_BASE) <= (ADDR_LIMIT - ADDR_BASE);
    empty        = cnt_q == '0;
    head_err     = ferr_q[rptr_q];
    head_disc    = fdisc_q[rptr_q];
    instr_gnt_o  = !rst && instr_req_i && cnt_q < FULL && (!arvalid_q || mem_arready_i);
    mem_rready_o = !empty && !head_err;
    pop          = !empty && (head_err || mem_rvalid_i);
    deliver      = pop && !head_disc && !flush_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ferr_q    <= '0;
      fdisc_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (flush_i) fdisc_q <= '1;
      if (instr_gnt_o) begin
        ferr_q[wptr_q]  <= !in_range;
        fdisc_q[wptr_q] <= 1'b0;
        wptr_q          <= nxt(wptr_q);
      end
      if (pop) rptr_q <= nxt(rptr_q);
      cnt_q    <= cnt_q + CW'(instr_gnt_o) - CW'(pop);
      rvalid_q <= deliver;
      if (deliver) begin
        rdata_q <= head_err ? '0 : mem_rdata_i;
        err_q   <= head_err | mem_rerr_i;
      end
      if (instr_gnt_o && in_range) begin
        arvalid_q <= 1'b1;
        araddr_q  <= {instr_addr_i[31:2], 2'b00};
      end else if (mem_arready_i) arvalid_q <= 1'b0;
    end
  end
  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign mem_arvalid_o  = arvalid_q;
  assign mem_araddr_o   = araddr_q;
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst) !(mem_rvalid_i && empty));
endmodule
